// File: rtl/arith_engine_pkg.sv
// ============================================================================
// Module  : arith_engine_pkg
// Brief   : Opcodes, FSM state encoding and flag bit positions shared by the
//           sequential arithmetic engine and its sub-blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_engine_pkg;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

`default_nettype wire

// File: rtl/seq_arith_engine_if.sv
// ============================================================================
// Module  : seq_arith_engine_if
// Brief   : Operand-issue and result-writeback handshakes of the engine.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_arith_engine_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             op_err;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, flags, op_err
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, flags, op_err
  );
endinterface

`default_nettype wire

// File: rtl/arith_mul_iter.sv
// ============================================================================
// Module  : arith_mul_iter
// Brief   : Unsigned shift-add multiplier, one multiplier bit per cycle, LSB
//           first, WIDTH iterations into a 2*WIDTH accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_mul_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start,
  input  wire logic [WIDTH-1:0]     a,
  input  wire logic [WIDTH-1:0]     b,
  output logic                      busy,
  output logic                      done,
  output logic [2*WIDTH-1:0]        product
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  // done flags the final iteration; product is the sum that lands this edge
  assign busy    = (r_cnt != '0);
  assign done    = (r_cnt == CNT_W'(1));
  assign product = w_acc_next;

endmodule

`default_nettype wire

// File: rtl/seq_arith_engine.sv
// ============================================================================
// Module  : seq_arith_engine
// Brief   : Handshaked arithmetic engine: one-cycle logic/add/sub ALU plus an
//           iterative multiply, registered result with N/Z/C/V flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_arith_engine
  import arith_engine_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input wire logic          clk,
  input wire logic          rst,
  seq_arith_engine_if.slave bus
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_op_err;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic               w_alu_err;
  logic [WIDTH-1:0]   w_res_sel;
  logic               w_c_sel;
  logic               w_v_sel;
  logic               w_err_sel;
  logic [3:0]         w_flags_sel;

  assign w_accept    = bus.in_valid && (r_state == IDLE);
  assign w_mul_start = w_accept && (bus.opcode == OP_MUL);

  arith_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_err = 1'b0;
    case (bus.opcode)
      OP_OR:   w_alu_res = bus.a | bus.b;
      OP_NAND: w_alu_res = ~(bus.a & bus.b);
      OP_NOR:  w_alu_res = ~(bus.a | bus.b);
      OP_AND:  w_alu_res = bus.a & bus.b;
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        // the extra top bit of the widened difference is the borrow
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL:  w_alu_res = '0;
      default: w_alu_err = 1'b1;
    endcase
  end

  // one result path feeds the output registers; MUL state selects the multiplier
  always_comb begin
    w_res_sel = w_alu_res;
    w_c_sel   = w_alu_c;
    w_v_sel   = w_alu_v;
    w_err_sel = w_alu_err;
    if (r_state == MUL) begin
      w_res_sel = w_mul_product[WIDTH-1:0];
      w_c_sel   = |w_mul_product[2*WIDTH-1:WIDTH];
      w_v_sel   = 1'b0;
      w_err_sel = 1'b0;
    end
    w_flags_sel        = '0;
    w_flags_sel[FLG_N] = w_res_sel[WIDTH-1];
    w_flags_sel[FLG_Z] = (w_res_sel == '0);
    w_flags_sel[FLG_C] = w_c_sel;
    w_flags_sel[FLG_V] = w_v_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_flags  <= '0;
      r_op_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (bus.opcode == OP_MUL) begin
              r_state <= MUL;
            end else begin
              r_state  <= DONE;
              r_result <= w_res_sel;
              r_flags  <= w_flags_sel;
              r_op_err <= w_err_sel;
            end
          end
        end
        MUL: begin
          if (w_mul_busy && w_mul_done) begin
            r_state  <= DONE;
            r_result <= w_res_sel;
            r_flags  <= w_flags_sel;
            r_op_err <= w_err_sel;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;
  assign bus.op_err    = r_op_err;

endmodule

`default_nettype wire

// File: doc/seq_arith_engine.md
# seq_arith_engine

Parametrised, handshaked successor to the 8-bit combinational arithmetic engine. It keeps the six logic/add/sub opcodes and adds a WIDTH parameter, registered results with a status-flag vector, an iterative shift-add multiply, and valid/ready flow control on both sides. It sits between an operand-issue stage and a result-writeback stage, and only one operation is in flight at a time.

## Interface
- WIDTH, 8: operand and result width. Legal range 4..32.
- CNT_W, $clog2(WIDTH+1): width of the multiply iteration counter. Derived; do not override.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  engine can accept a bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  3  000 OR, 001 NAND, 010 NOR, 011 AND, 100 ADD, 101 SUB (A-B), 110 MUL (low half), 111 illegal.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- flags  out  4  {negative, zero, carry, overflow}; bit 3 is negative.
- op_err  out  1  result came from the illegal opcode.

## Operation
- Accept occurs when in_valid && in_ready. Operands and opcode are captured at accept; later input changes are ignored.
- FSM states: IDLE, MUL, DONE.
  - IDLE to DONE: accept of any opcode other than 110.
  - IDLE to MUL: accept of 110.
  - MUL to DONE: when the counter reaches 0.
  - DONE to IDLE: when out_ready is high.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Logic ops: bitwise over the full WIDTH. carry = 0, overflow = 0.
- ADD: result = (A+B) mod 2^WIDTH.
  - carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - overflow = signed two's-complement overflow.
- SUB: result = (A-B) mod 2^WIDTH.
  - carry = borrow, i.e. A < B unsigned.
  - overflow = signed overflow of A-B.
- MUL: unsigned shift-add, one multiplier bit per cycle, LSB first, for WIDTH iterations. The accumulator is 2*WIDTH bits.
  - result = low WIDTH bits of the product.
  - carry = 1 if the high WIDTH bits are nonzero.
  - overflow = 0.
- All ops: zero = (result == 0); negative = result[WIDTH-1].
- Opcode 111: result = 0, flags = 0100 (zero only), op_err = 1. Otherwise op_err = 0.
- result, flags and op_err hold stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, flags 0000, op_err 0, counter 0.
- Non-MUL latency: accept in cycle N, out_valid high in cycle N+1.
- MUL latency: accept in cycle N, counter loads WIDTH, iterations run in cycles N+1..N+WIDTH, out_valid high in cycle N+WIDTH+1.
- Best-case throughput: one op per 2 cycles (IDLE, DONE). The engine does not accept in DONE, even when out_ready is high.
- in_valid while busy: ignored; in_ready stays 0. The producer must hold the bundle.
- out_ready high when out_valid is low: no effect.
- rst mid-MUL or in DONE: the op is abandoned with no output, and the next cycle shows reset values.
- rst and in_valid in the same cycle: rst wins; nothing is accepted.

## Structure
- Package arith_engine_pkg holds:
  - opcode constants OP_OR..OP_MUL and OP_ILL;
  - state enum IDLE/MUL/DONE;
  - flag bit-index constants FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0.
- One sub-module, arith_mul_iter (parameter WIDTH). It holds the iterative multiplier: accumulator, shifted multiplicand/multiplier and counter, with ports start, a, b, busy, done and product[2*WIDTH-1:0].
- The top level holds the FSM, the one-cycle ALU, flag generation and the output registers.

## Test plan
All at WIDTH=8.
- OR: a=0x0F, b=0xF0 -> result 0xFF, flags 1000, out_valid exactly 1 cycle after accept.
- ADD: a=0xFF, b=0x01 -> result 0x00, flags 0110.
- ADD signed overflow: a=0x7F, b=0x01 -> result 0x80, flags 1001.
- SUB underflow: a=0x00, b=0x01 -> result 0xFF, flags 1010.
- MUL:
  - a=0x0F, b=0x11 -> result 0xFF, flags 1000, out_valid exactly 9 cycles after accept, in_ready 0 throughout.
  - a=0x10, b=0x10 -> result 0x00, flags 0110.
- Backpressure and errors:
  - NAND a=0xAA, b=0xCC with out_ready low for 5 cycles -> result 0x77 held stable and in_ready 0 throughout; a new bundle presented meanwhile is not accepted.
  - Opcode 111 -> result 0, flags 0100, op_err 1.
- Reset mid-MUL: assert rst 4 cycles after accepting a MUL -> no out_valid pulse; next cycle shows reset values; a following AND a=0xF0, b=0xCC gives 0xC0 after 1 cycle.
